// File: rtl/mem_resp_tracker_pkg.sv
// mem_resp_tracker_pkg: load-control bit layout, entry states and entry record shared by the tracker.
package mem_resp_tracker_pkg;
    localparam int LD_CTRL_W = 5;
    localparam int LD_W  = 4;
    localparam int LD_B  = 3;
    localparam int LD_BU = 2;
    localparam int LD_H  = 1;
    localparam int LD_HU = 0;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_DONE} ent_state_e;

    typedef struct packed {
        ent_state_e           st;
        logic                 is_load;
        logic [LD_CTRL_W-1:0] ld_ctrl;
        logic [1:0]           offset;
        logic                 cancel;
        logic [31:0]          data;
    } entry_t;
endpackage

// File: rtl/mem_resp_tracker_align.sv
// mem_load_align: selects byte/half/word from a load beat and extends it per the load-control bits.
module mem_load_align
    import mem_resp_tracker_pkg::*;
(
    input  logic [LD_CTRL_W-1:0] ld_ctrl_i,
    input  logic [1:0]           offset_i,
    input  logic [31:0]          rdata_i,
    output logic [31:0]          result_o
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata_i[8*offset_i +: 8];
    assign h = rdata_i[16*offset_i[1] +: 16];
    // several control bits set at once OR their selections together
    assign result_o = ({32{ld_ctrl_i[LD_W]}}  & rdata_i)
                    | ({32{ld_ctrl_i[LD_B]}}  & {{24{b[7]}}, b})
                    | ({32{ld_ctrl_i[LD_BU]}} & {24'b0, b})
                    | ({32{ld_ctrl_i[LD_H]}}  & {{16{h[15]}}, h})
                    | ({32{ld_ctrl_i[LD_HU]}} & {16'b0, h});
endmodule

// File: rtl/mem_resp_tracker.sv
// mem_resp_tracker: in-order tracker for up to DEPTH outstanding data-SRAM requests,
// buffering aligned load responses against WB backpressure and dropping flushed ones.
module mem_resp_tracker
    import mem_resp_tracker_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b0,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 req_fire,
    input  logic                 req_is_load,
    input  logic [LD_CTRL_W-1:0] req_ld_ctrl,
    input  logic [1:0]           req_offset,
    output logic                 req_allow,
    input  logic                 data_ok,
    input  logic [31:0]          rdata,
    output logic                 resp_valid,
    output logic                 resp_is_load,
    output logic [31:0]          resp_data,
    input  logic                 resp_ready,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 proto_err
);
    localparam int PW = $clog2(DEPTH);

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d, data_ptr_q, data_ptr_d, head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             proto_err_q, proto_err_d;
    logic             full, alloc, dok, byp, pop, head_cancel;
    ent_state_e       head_st;
    logic [31:0]      aligned, load_data;

    assign head_st     = ent_q[head_ptr_q].st;
    assign head_cancel = ent_q[head_ptr_q].cancel;
    assign full        = cnt_q == CNT_W'(DEPTH);
    assign alloc       = req_fire & ~full;
    // data_ptr only ever rests on a non-WAIT entry when nothing is waiting
    assign dok         = data_ok & (ent_q[data_ptr_q].st == ST_WAIT);

    mem_load_align u_align (
        .ld_ctrl_i (ent_q[data_ptr_q].ld_ctrl),
        .offset_i  (ent_q[data_ptr_q].offset),
        .rdata_i   (rdata),
        .result_o  (aligned)
    );

    assign load_data    = ent_q[data_ptr_q].is_load ? aligned : '0;
    assign byp          = BYPASS && head_st == ST_WAIT && dok && !head_cancel && !flush;
    assign resp_valid   = ~flush & ((head_st == ST_DONE & ~head_cancel) | byp);
    assign resp_data    = !resp_valid ? '0 : byp ? load_data : ent_q[head_ptr_q].data;
    assign resp_is_load = ent_q[head_ptr_q].is_load;
    assign pop          = (resp_valid & resp_ready) | (head_st == ST_DONE & head_cancel);
    assign req_allow    = ~full;
    assign outstanding  = cnt_q;
    assign proto_err    = proto_err_q;

    always_comb begin
        ent_d       = ent_q;
        alloc_ptr_d = alloc_ptr_q;
        data_ptr_d  = data_ptr_q;
        head_ptr_d  = head_ptr_q;
        for (int i = 0; i < DEPTH; i++)
            if (flush && ent_q[i].st != ST_FREE) ent_d[i].cancel = 1'b1;
        if (dok) begin
            ent_d[data_ptr_q].st   = ST_DONE;
            ent_d[data_ptr_q].data = load_data;
            data_ptr_d             = data_ptr_q + PW'(1);
        end
        // a bypassed pop lands after the DONE write so the entry frees directly
        if (pop) begin
            ent_d[head_ptr_q].st = ST_FREE;
            head_ptr_d           = head_ptr_q + PW'(1);
        end
        if (alloc) begin
            ent_d[alloc_ptr_q] = '{st: ST_WAIT, is_load: req_is_load, ld_ctrl: req_ld_ctrl,
                                   offset: req_offset, cancel: flush, data: '0};
            alloc_ptr_d        = alloc_ptr_q + PW'(1);
        end
        cnt_d       = cnt_q + CNT_W'(alloc) - CNT_W'(pop);
        proto_err_d = proto_err_q | (req_fire & full) | (data_ok & ~dok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_q       <= '{default: '0};
            alloc_ptr_q <= '0;
            data_ptr_q  <= '0;
            head_ptr_q  <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            alloc_ptr_q <= alloc_ptr_d;
            data_ptr_q  <= data_ptr_d;
            head_ptr_q  <= head_ptr_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_mem_resp_tracker.sv
// tb_mem_resp_tracker: directed scenarios plus random traffic against a queue-based reference model.
module tb_mem_resp_tracker;
    localparam int DEPTH = 4;
    localparam logic [4:0] C_W = 5'b10000, C_B = 5'b01000, C_HU = 5'b00001;

    logic clk = 1'b0, resetn = 1'b0;
    logic flush, req_fire, req_is_load, data_ok, resp_ready;
    logic [4:0] req_ld_ctrl;
    logic [1:0] req_offset;
    logic [31:0] rdata;
    logic req_allow, resp_valid, resp_is_load, proto_err;
    logic [31:0] resp_data;
    logic [2:0] outstanding;

    logic b_flush, b_req_fire, b_req_is_load, b_data_ok, b_resp_ready;
    logic [4:0] b_req_ld_ctrl;
    logic [1:0] b_req_offset;
    logic [31:0] b_rdata;
    logic b_req_allow, b_resp_valid, b_resp_is_load, b_proto_err;
    logic [31:0] b_resp_data;
    logic [2:0] b_outstanding;

    int checks = 0, errors = 0;

    typedef struct packed {
        bit ld; bit [4:0] c; bit [1:0] off; bit cancel; bit done; bit [31:0] data;
    } ref_t;
    ref_t q[$];
    bit m_perr;
    logic [31:0] popped[$];

    always #5 clk = ~clk;

    mem_resp_tracker #(.DEPTH(DEPTH), .BYPASS(1'b0)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .req_fire(req_fire), .req_is_load(req_is_load),
        .req_ld_ctrl(req_ld_ctrl), .req_offset(req_offset), .req_allow(req_allow), .data_ok(data_ok),
        .rdata(rdata), .resp_valid(resp_valid), .resp_is_load(resp_is_load), .resp_data(resp_data),
        .resp_ready(resp_ready), .outstanding(outstanding), .proto_err(proto_err)
    );

    mem_resp_tracker #(.DEPTH(DEPTH), .BYPASS(1'b1)) u_byp (
        .clk(clk), .resetn(resetn), .flush(b_flush), .req_fire(b_req_fire), .req_is_load(b_req_is_load),
        .req_ld_ctrl(b_req_ld_ctrl), .req_offset(b_req_offset), .req_allow(b_req_allow), .data_ok(b_data_ok),
        .rdata(b_rdata), .resp_valid(b_resp_valid), .resp_is_load(b_resp_is_load), .resp_data(b_resp_data),
        .resp_ready(b_resp_ready), .outstanding(b_outstanding), .proto_err(b_proto_err)
    );

    task automatic chk(string tag, logic [31:0] got_v, logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got_v, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] ref_align(bit [4:0] c, bit [1:0] off, bit [31:0] d);
        int unsigned b, h;
        logic [31:0] r;
        b = (d >> (8 * off)) & 255;
        h = (d >> (16 * (off / 2))) & 65535;
        r = 0;
        if (c[4]) r |= d;
        if (c[3]) r |= (b >= 128) ? b + 32'hFFFFFF00 : b;
        if (c[2]) r |= b;
        if (c[1]) r |= (h >= 32768) ? h + 32'hFFFF0000 : h;
        if (c[0]) r |= h;
        return r;
    endfunction

    function automatic bit has_wait();
        foreach (q[i]) if (!q[i].done) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        flush = 0; req_fire = 0; req_is_load = 0; req_ld_ctrl = 0; req_offset = 0;
        data_ok = 0; rdata = 0; resp_ready = 0;
    endtask

    task automatic b_idle();
        b_flush = 0; b_req_fire = 0; b_req_is_load = 0; b_req_ld_ctrl = 0; b_req_offset = 0;
        b_data_ok = 0; b_rdata = 0; b_resp_ready = 0;
    endtask

    // Check the main DUT against the model, advance the model over the coming edge, land on the next negedge.
    task automatic cyc();
        int n0, k;
        bit ev, pop;
        #1;
        n0 = q.size();
        chk("outstanding", 32'(outstanding), n0);
        chk("req_allow", 32'(req_allow), 32'(n0 < DEPTH));
        ev = n0 > 0 && q[0].done && !q[0].cancel && !flush;
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        if (ev) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_is_load", 32'(resp_is_load), 32'(q[0].ld));
        end
        chk("proto_err", 32'(proto_err), 32'(m_perr));
        if (resp_valid && resp_ready) popped.push_back(resp_data);
        pop = (ev && resp_ready) || (n0 > 0 && q[0].done && q[0].cancel);
        if (flush) foreach (q[i]) q[i].cancel = 1'b1;
        if (data_ok) begin
            k = -1;
            foreach (q[i]) if (k < 0 && !q[i].done) k = i;
            if (k < 0) m_perr = 1'b1;
            else begin
                q[k].done = 1'b1;
                q[k].data = q[k].ld ? ref_align(q[k].c, q[k].off, rdata) : 32'h0;
            end
        end
        if (pop) void'(q.pop_front());
        if (req_fire) begin
            if (n0 < DEPTH) q.push_back('{ld: req_is_load, c: req_ld_ctrl, off: req_offset,
                                          cancel: flush, done: 1'b0, data: 32'h0});
            else m_perr = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic fire(logic [4:0] c, logic [1:0] off);
        req_fire = 1; req_is_load = 1; req_ld_ctrl = c; req_offset = off;
    endtask

    task automatic drain(int n);
        repeat (n) begin
            idle();
            resp_ready = 1;
            data_ok = has_wait();
            rdata = $urandom;
            cyc();
        end
    endtask

    initial begin
        idle();
        b_idle();
        m_perr = 0;
        #2;
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_req_allow", 32'(req_allow), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(negedge clk);
        resetn = 1;

        // back-to-back ld.b across all four byte lanes
        popped.delete();
        for (int i = 0; i < 5; i++) begin
            idle();
            resp_ready = 1;
            if (i < 4) fire(C_B, i[1:0]);
            data_ok = i > 0;
            rdata = 32'h80FF7F01;
            cyc();
        end
        drain(3);
        chk("ldb_count", popped.size(), 4);
        if (popped.size() == 4) begin
            chk("ldb_0", popped[0], 32'h00000001);
            chk("ldb_1", popped[1], 32'h0000007F);
            chk("ldb_2", popped[2], 32'hFFFFFFFF);
            chk("ldb_3", popped[3], 32'hFFFFFF80);
        end

        // fill, then one illegal request
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            fire(C_W, 2'd0);
            cyc();
        end
        idle();
        chk("full_allow", 32'(req_allow), 0);
        fire(C_W, 2'd0);
        cyc();
        idle();
        chk("full_perr", 32'(proto_err), 1);
        chk("full_outstanding", 32'(outstanding), 4);
        drain(8);

        // asynchronous reset with three loads waiting
        for (int i = 0; i < 3; i++) begin
            idle();
            fire(C_W, 2'd0);
            cyc();
        end
        idle();
        chk("pre_rst_outstanding", 32'(outstanding), 3);
        #3;
        resetn = 0;
        #1;
        chk("arst_outstanding", 32'(outstanding), 0);
        chk("arst_resp_valid", 32'(resp_valid), 0);
        chk("arst_req_allow", 32'(req_allow), 1);
        chk("arst_proto_err", 32'(proto_err), 0);
        q.delete();
        m_perr = 0;
        @(negedge clk);
        resetn = 1;

        // flush two waiting loads, their beats are discarded
        for (int i = 0; i < 2; i++) begin
            idle();
            fire(C_W, 2'd0);
            cyc();
        end
        idle();
        flush = 1;
        cyc();
        idle();
        chk("flush_outstanding", 32'(outstanding), 2);
        for (int i = 0; i < 2; i++) begin
            idle();
            resp_ready = 1;
            data_ok = 1;
            rdata = $urandom;
            #1;
            chk("flush_no_valid", 32'(resp_valid), 0);
            cyc();
        end
        idle();
        resp_ready = 1;
        cyc();
        cyc();
        chk("flush_drained", 32'(outstanding), 0);
        idle();
        fire(C_HU, 2'd2);
        cyc();
        idle();
        resp_ready = 1;
        data_ok = 1;
        rdata = 32'hBEEF0000;
        cyc();
        idle();
        resp_ready = 1;
        #1;
        chk("ldhu_valid", 32'(resp_valid), 1);
        chk("ldhu_data", resp_data, 32'h0000BEEF);
        cyc();

        // backpressure: three responses buffered, then drained back to back
        idle();
        fire(C_W, 2'd0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i < 2) fire(C_W, 2'd0);
            data_ok = 1;
            rdata = 32'hA0000000 + i;
            cyc();
        end
        idle();
        cyc();
        chk("bp_outstanding", 32'(outstanding), 3);
        for (int i = 0; i < 3; i++) begin
            idle();
            resp_ready = 1;
            #1;
            chk("bp_valid", 32'(resp_valid), 1);
            chk("bp_data", resp_data, 32'hA0000000 + i);
            cyc();
        end
        idle();
        chk("bp_empty", 32'(outstanding), 0);

        // registered response is one cycle after data_ok
        fire(C_W, 2'd0);
        cyc();
        idle();
        resp_ready = 1;
        data_ok = 1;
        rdata = 32'h12345678;
        #1;
        chk("reg_same_cycle", 32'(resp_valid), 0);
        cyc();
        idle();
        resp_ready = 1;
        #1;
        chk("reg_next_valid", 32'(resp_valid), 1);
        chk("reg_next_data", resp_data, 32'h12345678);
        cyc();

        // bypass instance: same-cycle response, held response, flushed beat
        idle();
        b_req_fire = 1; b_req_is_load = 1; b_req_ld_ctrl = C_W;
        cyc();
        b_idle();
        b_data_ok = 1; b_rdata = 32'h12345678; b_resp_ready = 1;
        #1;
        chk("byp_valid", 32'(b_resp_valid), 1);
        chk("byp_data", b_resp_data, 32'h12345678);
        cyc();
        b_idle();
        chk("byp_freed", 32'(b_outstanding), 0);
        b_req_fire = 1; b_req_is_load = 1; b_req_ld_ctrl = C_B; b_req_offset = 2'd1;
        cyc();
        b_idle();
        b_data_ok = 1; b_rdata = 32'h0000F000;
        #1;
        chk("byp_hold_valid", 32'(b_resp_valid), 1);
        chk("byp_hold_data", b_resp_data, 32'hFFFFFFF0);
        cyc();
        b_idle();
        chk("byp_held_valid", 32'(b_resp_valid), 1);
        chk("byp_held_data", b_resp_data, 32'hFFFFFFF0);
        chk("byp_held_cnt", 32'(b_outstanding), 1);
        b_resp_ready = 1;
        cyc();
        b_idle();
        chk("byp_held_freed", 32'(b_outstanding), 0);
        b_req_fire = 1; b_req_is_load = 1; b_req_ld_ctrl = C_W;
        cyc();
        b_idle();
        b_data_ok = 1; b_rdata = 32'hCAFEF00D; b_flush = 1; b_resp_ready = 1;
        #1;
        chk("byp_flush_valid", 32'(b_resp_valid), 0);
        cyc();
        b_idle();
        b_resp_ready = 1;
        #1;
        chk("byp_flushed_valid", 32'(b_resp_valid), 0);
        cyc();
        b_idle();
        chk("byp_flushed_cnt", 32'(b_outstanding), 0);
        chk("byp_perr", 32'(b_proto_err), 0);

        // random legal traffic
        for (int n = 0; n < 800; n++) begin
            idle();
            resp_ready = $urandom_range(9) < 7;
            flush = $urandom_range(19) == 0;
            if (q.size() < DEPTH && $urandom_range(1) == 1) begin
                req_fire = 1;
                req_is_load = 1'($urandom);
                req_ld_ctrl = ($urandom_range(3) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(4));
                req_offset = 2'($urandom);
            end
            data_ok = has_wait() && $urandom_range(1) == 1;
            rdata = $urandom;
            cyc();
        end
        drain(12);
        idle();
        chk("end_outstanding", 32'(outstanding), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
